pipelined_data_path: RTL
========================

// Module: pipelined_data_path
// PURPOSE
// - 5-stage (F/D/E/M/W) parametrised successor of the single-cycle RV32I datapath.
// - Holds PC, pipeline registers, register file, ALU, immediate generator and hazard/forwarding unit.
// - Sits between the combinational controller (decodes InstrD) and instruction/data memories.
// - One instruction retired per cycle absent hazards; control decoded in D and carried down the pipe.
// PARAMETERS
// - XLEN      32            datapath/register/PC width (>=32)
// - RESET_PC  32'h0000_0000 PC value loaded on reset
// - NOP_INSTR 32'h0000_0013 instruction injected into D on flush/reset (addi x0,x0,0)
// PORTS
// - clk          in   1     single clock, all state on posedge
// - reset        in   1     synchronous, active-high
// - PCF          out  XLEN  fetch address to instruction memory
// - InstrF       in   32    instruction read at PCF (combinational memory)
// - InstrD       out  32    D-stage instruction to controller
// - RegWriteD    in   1     controller: write rd
// - ResultSrcD   in   2     00 ALU, 01 ReadData, 10 PC+4
// - MemWriteD    in   1     controller: store
// - JumpD        in   1     jal/jalr
// - JalrD        in   1     target from ALU (jalr), else PC+imm
// - BranchD      in   1     beq-type branch (taken on Zero)
// - ALUControlD  in   3     ALU op, same encoding as existing ALU
// - ALUSrcD      in   1     0 rs2, 1 immediate
// - ImmSrcD      in   2     immediate format, same encoding as existing generator
// - MemWriteM    out  1     store strobe to data memory
// - ALUResultM   out  XLEN  data memory address
// - WriteDataM   out  XLEN  store data
// - ReadDataM    in   XLEN  load data (combinational memory)
// BEHAVIOUR
// - Reset (sync): PCF=RESET_PC; InstrD=NOP_INSTR; all E/M/W control bits 0 (bubbles);
//   MemWriteM=0, ALUResultM=0, WriteDataM=0; register file cleared to 0. Reset mid-run discards all in flight.
// - PC: PCNext = PCSrcE ? PCTargetE : PCF+4; PCSrcE=(BranchE&ZeroE)|JumpE.
//   PCTargetE = JalrE ? (ALUResultE & ~1) : PCE+ImmExtE. Arithmetic modulo 2^XLEN (wraps silently).
// - Regfile: x0 reads 0, writes to x0 ignored; write in W; D-stage read of rd being written in W
//   returns ResultW same cycle (write-through bypass).
// - Forwarding (E operands): rs==rdM & RegWriteM & rs!=0 -> ALUResultM (priority);
//   else rs==rdW & RegWriteW & rs!=0 -> ResultW; else register value.
// - Load-use: ResultSrcE==01 & rdE!=0 & rdE in {rs1D,rs2D} -> stall F,D 1 cycle, bubble E.
// - Taken branch/jump in E: flush D (NOP_INSTR) and E (bubble) next edge; penalty 2 cycles.
// - Simultaneous stall and flush: flush wins (stalled instr is on wrong path); PC takes PCTargetE.
// - Bubble = all control bits 0; rd fields zeroed so no false hazard matches.
// - Latency: rd visible to dependent instr immediately behind (forwarding), result written 4 cycles after D.
// CONFIGURATION
// - FORWARDING_EN defined: forwarding paths and load-use stall as above.
// - FORWARDING_EN undefined: no E-stage forwarding; any RAW on rdE or rdM (rd!=0, RegWrite set)
//   stalls F,D and bubbles E until producer reaches W (W covered by regfile bypass).
// - Architectural results identical in both configs; only cycle counts differ.
// TESTING
// - Reset held 2 cycles then released -> PCF=0,4,8 on successive cycles; MemWriteM=0 throughout reset.
// - addi x1,x0,5; add x2,x1,x1 back-to-back -> x2=10, no stall with FORWARDING_EN, 2 stall cycles without.
// - lw x3,0(x0) (mem[0]=0x7); add x4,x3,x3 -> exactly 1 stall cycle, x4=0xE.
// - beq x0,x0,+16 at PC 0x20 -> two flushed bubbles, next fetched PC 0x30, no side effects from 0x24/0x28.
// - jalr x1,12(x5) with x5=0x101 -> PC=0x10C (LSB cleared), x1=PC_jalr+4.
// - Writes to x0 then read x0 -> 0; store sw x2,8(x0) -> MemWriteM=1, ALUResultM=8, WriteDataM=10.

Source files
------------

// File: rtl/pipelined_data_path.sv
// rtl/pipelined_data_path.sv - 5-stage F/D/E/M/W RV32I datapath with hazard unit
// Optional macro FORWARDING_EN: E-stage forwarding with load-use stall; otherwise stall on any in-flight RAW.
module pipelined_data_path #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] PCF,
    input  logic [31:0]     InstrF,
    output logic [31:0]     InstrD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            JalrD,
    input  logic            BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ImmSrcD,
    output logic            MemWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ReadDataM
);

    logic [XLEN-1:0] pc_plus4_f, pc_d, pc_plus4_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;
    logic [XLEN-1:0] rf [32];

    logic            reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, alu_src_e;
    logic [1:0]      result_src_e;
    logic [2:0]      alu_control_e;
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e;
    logic [4:0]      rd_e;
    logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e, pc_target_e;
    logic            zero_e, pc_src_e;

    logic            reg_write_m;
    logic [1:0]      result_src_m;
    logic [4:0]      rd_m;
    logic [XLEN-1:0] pc_plus4_m;

    logic            reg_write_w;
    logic [1:0]      result_src_w;
    logic [4:0]      rd_w;
    logic [XLEN-1:0] alu_result_w, read_data_w, pc_plus4_w, result_w;

    logic            stall, flush_d, flush_e;

    // Redirect beats stall: a stalled instruction behind a taken branch is on the wrong path.
    assign pc_plus4_f = PCF + XLEN'(4);
    assign flush_d    = pc_src_e;
    assign flush_e    = pc_src_e | stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (pc_src_e) begin
            PCF <= pc_target_e;
        end else if (!stall) begin
            PCF <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_d) begin
            InstrD     <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (!stall) begin
            InstrD     <= InstrF;
            pc_d       <= PCF;
            pc_plus4_d <= pc_plus4_f;
        end
    end

    assign rs1_d = InstrD[19:15];
    assign rs2_d = InstrD[24:20];
    assign rd_d  = InstrD[11:7];

    always_comb begin
        case (ImmSrcD)
            2'b00:   imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            2'b01:   imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10:   imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                                  InstrD[11:8], 1'b0};
            default: imm_ext_d = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                                  InstrD[30:21], 1'b0};
        endcase
    end

    // Write-through: a D read of the register W is writing sees the new value this cycle.
    always_comb begin
        rd1_d = rf[rs1_d];
        rd2_d = rf[rs2_d];
        if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_d) rd1_d = result_w;
        if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_d) rd2_d = result_w;
        if (rs1_d == 5'd0) rd1_d = '0;
        if (rs2_d == 5'd0) rd2_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (reg_write_w && rd_w != 5'd0) begin
            rf[rd_w] <= result_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            reg_write_e   <= 1'b0;
            result_src_e  <= 2'b00;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            jalr_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            pc_e          <= '0;
            imm_ext_e     <= '0;
            pc_plus4_e    <= '0;
            rd_e          <= 5'd0;
        end else begin
            reg_write_e   <= RegWriteD;
            result_src_e  <= ResultSrcD;
            mem_write_e   <= MemWriteD;
            jump_e        <= JumpD;
            jalr_e        <= JalrD;
            branch_e      <= BranchD;
            alu_control_e <= ALUControlD;
            alu_src_e     <= ALUSrcD;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            pc_e          <= pc_d;
            imm_ext_e     <= imm_ext_d;
            pc_plus4_e    <= pc_plus4_d;
            rd_e          <= rd_d;
        end
    end

`ifdef FORWARDING_EN
    logic [4:0] rs1_e, rs2_e;

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rs1_e <= 5'd0;
            rs2_e <= 5'd0;
        end else begin
            rs1_e <= rs1_d;
            rs2_e <= rs2_d;
        end
    end

    // M has priority over W: it holds the younger producer.
    always_comb begin
        src_a_e      = rd1_e;
        write_data_e = rd2_e;
        if (rs1_e != 5'd0 && reg_write_m && rs1_e == rd_m)      src_a_e = ALUResultM;
        else if (rs1_e != 5'd0 && reg_write_w && rs1_e == rd_w) src_a_e = result_w;
        if (rs2_e != 5'd0 && reg_write_m && rs2_e == rd_m)      write_data_e = ALUResultM;
        else if (rs2_e != 5'd0 && reg_write_w && rs2_e == rd_w) write_data_e = result_w;
    end

    assign stall = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                   (rd_e == rs1_d || rd_e == rs2_d);
`else
    assign src_a_e      = rd1_e;
    assign write_data_e = rd2_e;

    // Hold D until the producer reaches W, where the regfile bypass delivers it.
    assign stall = (reg_write_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d)) ||
                   (reg_write_m && rd_m != 5'd0 && (rd_m == rs1_d || rd_m == rs2_d));
`endif

    assign src_b_e = alu_src_e ? imm_ext_e : write_data_e;

    always_comb begin
        case (alu_control_e)
            3'b000:  alu_result_e = src_a_e + src_b_e;
            3'b001:  alu_result_e = src_a_e - src_b_e;
            3'b010:  alu_result_e = src_a_e & src_b_e;
            3'b011:  alu_result_e = src_a_e | src_b_e;
            3'b101:  alu_result_e = {{(XLEN-1){1'b0}}, $signed(src_a_e) < $signed(src_b_e)};
            default: alu_result_e = '0;
        endcase
    end

    assign zero_e      = (alu_result_e == '0);
    assign pc_target_e = jalr_e ? {alu_result_e[XLEN-1:1], 1'b0} : pc_e + imm_ext_e;
    assign pc_src_e    = (branch_e & zero_e) | jump_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            MemWriteM    <= 1'b0;
            ALUResultM   <= '0;
            WriteDataM   <= '0;
            rd_m         <= 5'd0;
            pc_plus4_m   <= '0;
        end else begin
            reg_write_m  <= reg_write_e;
            result_src_m <= result_src_e;
            MemWriteM    <= mem_write_e;
            ALUResultM   <= alu_result_e;
            WriteDataM   <= write_data_e;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_plus4_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            alu_result_w <= '0;
            read_data_w  <= '0;
            rd_w         <= 5'd0;
            pc_plus4_w   <= '0;
        end else begin
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            alu_result_w <= ALUResultM;
            read_data_w  <= ReadDataM;
            rd_w         <= rd_m;
            pc_plus4_w   <= pc_plus4_m;
        end
    end

    always_comb begin
        case (result_src_w)
            2'b01:   result_w = read_data_w;
            2'b10:   result_w = pc_plus4_w;
            default: result_w = alu_result_w;
        endcase
    end

endmodule
